// File: rtl/sample_sequencer_pkg.sv
// rtl/sample_sequencer_pkg.sv - shared constants and types for the sample sequencer
//
// Contents:
//   seq_state_t       sequencer state encoding (IDLE, RUN, DRAIN)
//   MAX_QUADS         depth of the sample buffer (largest legal NUM_QUADS)
//   BUF_AW            sample buffer address width
//   DEFAULT_SRC_BASE  default register address read into entry 1
//   quad_addr()       register address for a given entry index, wraps modulo 2^16

package sample_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } seq_state_t;

   localparam int          MAX_QUADS        = 64;
   localparam int          BUF_AW           = 6;
   localparam logic [15:0] DEFAULT_SRC_BASE = 16'h0000;

   // Entry k is read from base+k-1; 16-bit arithmetic wraps naturally.
   function automatic logic [15:0] quad_addr(input logic [15:0] base, input logic [6:0] idx);
      return base + {9'd0, idx} - 16'd1;
   endfunction

endpackage

// File: rtl/sample_buf_dp.sv
// rtl/sample_buf_dp.sv - 64x32 sample buffer, one write port, one registered read port
//
// Ports:
//   clk    system clock
//   rst    asynchronous active-high reset, clears only the read data register
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  registered read data, entry[raddr] one cycle after the address

module sample_buf_dp
   import sample_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [BUF_AW-1:0] waddr,
   input  logic [31:0]       wdata,
   input  logic [BUF_AW-1:0] raddr,
   output logic [31:0]       rdata
);

   logic [31:0] mem [0:MAX_QUADS-1];

   // Storage has no reset so it maps onto block RAM; contents survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read-before-write: a read of the entry written on the same edge returns the old value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/sample_sequencer.sv
// rtl/sample_sequencer.sv - captures a timestamp plus NUM_QUADS-1 register reads into a sample buffer
//
// Parameters:
//   NUM_QUADS     buffer entries filled per sample (2..64)
//   SRC_BASE      register address read into entry 1
// Ports:
//   sysclk        system clock
//   reset         asynchronous active-high reset
//   sample_start  one-cycle request to begin a sample
//   sample_busy   sample in progress
//   timestamp     free-running timestamp, written to entry 0 at start
//   sample_raddr  sample buffer read address
//   sample_rdata  sample buffer read data, one cycle after the address
//   host_ren      host claims the shared register read port this cycle
//   host_raddr    host read address
//   bus_raddr     address driven to the shared register read port
//   bus_rdata     register read data, valid one cycle after its address

module sample_sequencer
   import sample_sequencer_pkg::*;
#(
   parameter int          NUM_QUADS = 5,
   parameter logic [15:0] SRC_BASE  = DEFAULT_SRC_BASE
)
(
   input  logic        sysclk,
   input  logic        reset,
   input  logic        sample_start,
   output logic        sample_busy,
   input  logic [31:0] timestamp,
   input  logic [5:0]  sample_raddr,
   output logic [31:0] sample_rdata,
   input  logic        host_ren,
   input  logic [15:0] host_raddr,
   output logic [15:0] bus_raddr,
   input  logic [31:0] bus_rdata
);

   localparam logic [6:0] LAST_IDX = 7'(NUM_QUADS - 1);

   seq_state_t  state;
   logic        pending;
   logic [6:0]  idx;
   logic [6:0]  pidx;

   logic        buf_we;
   logic [5:0]  buf_waddr;
   logic [31:0] buf_wdata;

   // Host always wins the shared read port; our read simply slips a cycle.
   assign bus_raddr = host_ren ? host_raddr : quad_addr(SRC_BASE, idx);

   // Single write port: a pending register read lands one cycle after its
   // issue; the timestamp is written on the start edge, when nothing is pending.
   // Writes are suppressed while reset is asserted so an abandoned sample
   // leaves the buffer untouched.
   always_comb begin
      buf_we    = 1'b0;
      buf_waddr = '0;
      buf_wdata = '0;
      if (!reset) begin
         if (pending && !pidx[6]) begin
            buf_we    = 1'b1;
            buf_waddr = pidx[5:0];
            buf_wdata = bus_rdata;
         end else if (state == ST_IDLE && sample_start) begin
            buf_we    = 1'b1;
            buf_waddr = '0;
            buf_wdata = timestamp;
         end
      end
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         sample_busy <= 1'b0;
         pending     <= 1'b0;
         idx         <= '0;
         pidx        <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               pending <= 1'b0;
               if (sample_start) begin
                  idx         <= 7'd1;
                  sample_busy <= 1'b1;
                  state       <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (!host_ren) begin
                  pending <= 1'b1;
                  pidx    <= idx;
                  idx     <= idx + 7'd1;
                  if (idx == LAST_IDX) begin
                     state <= ST_DRAIN;
                  end
               end else begin
                  // Stall: the host owns this cycle's read, nothing to capture next edge.
                  pending <= 1'b0;
               end
            end
            ST_DRAIN: begin
               // The last pending entry is written by the buffer port on this edge.
               pending     <= 1'b0;
               sample_busy <= 1'b0;
               state       <= ST_IDLE;
            end
            default: begin
               pending     <= 1'b0;
               sample_busy <= 1'b0;
               state       <= ST_IDLE;
            end
         endcase
      end
   end

   sample_buf_dp u_buf (
      .clk   (sysclk),
      .rst   (reset),
      .we    (buf_we),
      .waddr (buf_waddr),
      .wdata (buf_wdata),
      .raddr (sample_raddr),
      .rdata (sample_rdata)
   );

endmodule

// File: tb/tb_sample_sequencer.sv
// tb/tb_sample_sequencer.sv - directed self-checking bench for sample_sequencer

module tb_sample_sequencer;

   logic        sysclk = 1'b0;
   logic        reset;
   logic        start_a;
   logic        start_b;
   logic        host_ren;
   logic [15:0] host_raddr;
   logic [31:0] timestamp;
   logic [5:0]  sample_raddr;
   logic        busy_a;
   logic        busy_b;
   logic [31:0] rdata_a;
   logic [31:0] rdata_b;
   logic [15:0] braddr_a;
   logic [15:0] braddr_b;
   logic [31:0] brdata_a = '0;
   logic [31:0] brdata_b = '0;
   logic [31:0] bus_ofs;
   logic [31:0] rd_hist [0:31];

   int tests = 0;
   int fails = 0;
   int n;

   always #5 sysclk = ~sysclk;

   // Register file model: data = bus_ofs + address, one cycle after the address.
   always @(posedge sysclk) begin
      brdata_a <= bus_ofs + {16'h0000, braddr_a};
      brdata_b <= bus_ofs + {16'h0000, braddr_b};
   end

   sample_sequencer #(.NUM_QUADS(5), .SRC_BASE(16'h0010)) u_dut_a (
      .sysclk       (sysclk),
      .reset        (reset),
      .sample_start (start_a),
      .sample_busy  (busy_a),
      .timestamp    (timestamp),
      .sample_raddr (sample_raddr),
      .sample_rdata (rdata_a),
      .host_ren     (host_ren),
      .host_raddr   (host_raddr),
      .bus_raddr    (braddr_a),
      .bus_rdata    (brdata_a)
   );

   sample_sequencer #(.NUM_QUADS(64), .SRC_BASE(16'hFFF0)) u_dut_b (
      .sysclk       (sysclk),
      .reset        (reset),
      .sample_start (start_b),
      .sample_busy  (busy_b),
      .timestamp    (timestamp),
      .sample_raddr (sample_raddr),
      .sample_rdata (rdata_b),
      .host_ren     (1'b0),
      .host_raddr   (host_raddr),
      .bus_raddr    (braddr_b),
      .bus_rdata    (brdata_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge sysclk);
      #1;
   endtask

   task automatic read_a(input logic [5:0] a, input logic [31:0] exp, input string tag);
      sample_raddr = a;
      step();
      check(tag, rdata_a, exp);
   endtask

   task automatic read_b(input logic [5:0] a, input logic [31:0] exp, input string tag);
      sample_raddr = a;
      step();
      check(tag, rdata_b, exp);
   endtask

   // One sample on instance A; s1/s2 are host-stall cycles, restart_c a repeated start.
   task automatic run_a(input logic [31:0] ts, input int s1, input int s2, input int restart_c,
                        output int busy_cycles);
      int m_idx;
      timestamp = ts;
      start_a   = 1'b1;
      host_ren  = 1'b0;
      step();
      start_a     = 1'b0;
      timestamp   = 32'hFFFF_0000;
      busy_cycles = 0;
      m_idx       = 1;
      for (int c = 1; c <= 20; c++) begin
         host_ren   = (c == s1) || (c == s2);
         host_raddr = 16'h0400;
         start_a    = (c == restart_c);
         #1;
         rd_hist[c] = rdata_a;
         if (!busy_a) break;
         busy_cycles++;
         if (host_ren) begin
            check("bus_raddr_host", {16'h0000, braddr_a}, 32'h0000_0400);
         end else if (m_idx <= 4) begin
            check("bus_raddr_issue", {16'h0000, braddr_a}, 32'h0000_000F + m_idx);
            m_idx++;
         end
         step();
      end
      host_ren = 1'b0;
      start_a  = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      start_a      = 1'b0;
      start_b      = 1'b0;
      host_ren     = 1'b0;
      host_raddr   = '0;
      timestamp    = '0;
      sample_raddr = '0;
      bus_ofs      = 32'h0000_A000;
      repeat (2) step();

      check("rst_busy_a", {31'd0, busy_a}, 32'd0);
      check("rst_busy_b", {31'd0, busy_b}, 32'd0);
      check("rst_rdata_a", rdata_a, 32'd0);
      check("rst_rdata_b", rdata_b, 32'd0);
      reset = 1'b0;
      #1;
      check("idle_raddr_a", {16'h0000, braddr_a}, 32'h0000_000F);
      check("idle_raddr_b", {16'h0000, braddr_b}, 32'h0000_FFEF);
      host_ren   = 1'b1;
      host_raddr = 16'h1234;
      #1;
      check("host_mux", {16'h0000, braddr_a}, 32'h0000_1234);
      host_ren = 1'b0;
      step();

      // Plain sample
      run_a(32'h0000_1234, 0, 0, 0, n);
      check("busy_nostall", n, 5);
      read_a(6'd0, 32'h0000_1234, "s1_e0");
      read_a(6'd1, 32'h0000_A010, "s1_e1");
      read_a(6'd2, 32'h0000_A011, "s1_e2");
      read_a(6'd3, 32'h0000_A012, "s1_e3");
      read_a(6'd4, 32'h0000_A013, "s1_e4");

      // Host stalls on cycles 2 and 3
      run_a(32'h0000_5678, 2, 3, 0, n);
      check("busy_stall", n, 7);
      read_a(6'd0, 32'h0000_5678, "s2_e0");
      read_a(6'd1, 32'h0000_A010, "s2_e1");
      read_a(6'd2, 32'h0000_A011, "s2_e2");
      read_a(6'd3, 32'h0000_A012, "s2_e3");
      read_a(6'd4, 32'h0000_A013, "s2_e4");

      // Repeated start mid-sample is ignored
      run_a(32'h0000_9ABC, 0, 0, 2, n);
      check("busy_restart", n, 5);
      read_a(6'd0, 32'h0000_9ABC, "s3_e0");

      // Start in the DRAIN cycle is ignored
      run_a(32'h0000_1111, 0, 0, 5, n);
      check("busy_drain_start", n, 5);
      step();
      check("idle_after_drain", {31'd0, busy_a}, 32'd0);

      // Read of entry 3 across its own write
      sample_raddr = 6'd3;
      bus_ofs      = 32'h0000_B000;
      run_a(32'h0000_2222, 0, 0, 0, n);
      check("busy_rdw", n, 5);
      check("rdw_old", rd_hist[5], 32'h0000_A012);
      check("rdw_new", rd_hist[6], 32'h0000_B012);

      // Reset two cycles after start
      bus_ofs   = 32'h0000_C000;
      timestamp = 32'h0000_3333;
      start_a   = 1'b1;
      step();
      start_a = 1'b0;
      step();
      reset = 1'b1;
      #1;
      check("midrst_busy", {31'd0, busy_a}, 32'd0);
      check("midrst_rdata", rdata_a, 32'd0);
      step();
      reset = 1'b0;
      repeat (3) step();
      read_a(6'd3, 32'h0000_B012, "midrst_e3");
      read_a(6'd4, 32'h0000_B013, "midrst_e4");
      bus_ofs = 32'h0000_A000;
      run_a(32'h0000_4444, 0, 0, 0, n);
      check("busy_after_rst", n, 5);
      read_a(6'd0, 32'h0000_4444, "postrst_e0");
      read_a(6'd1, 32'h0000_A010, "postrst_e1");
      read_a(6'd4, 32'h0000_A013, "postrst_e4");

      // 64-entry instance with wrapping source address
      timestamp = 32'h0000_6464;
      start_b   = 1'b1;
      step();
      start_b = 1'b0;
      n       = 0;
      for (int c = 1; c <= 100; c++) begin
         #1;
         if (!busy_b) break;
         n++;
         if (c == 16) check("wrap_ffff", {16'h0000, braddr_b}, 32'h0000_FFFF);
         if (c == 17) check("wrap_0000", {16'h0000, braddr_b}, 32'h0000_0000);
         step();
      end
      check("busy_64", n, 64);
      read_b(6'd0,  32'h0000_6464, "b_e0");
      read_b(6'd1,  32'h0001_9FF0, "b_e1");
      read_b(6'd16, 32'h0001_9FFF, "b_e16");
      read_b(6'd17, 32'h0000_A000, "b_e17");
      read_b(6'd63, 32'h0000_A02E, "b_e63");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sample_sequencer.md
SAMPLE_SEQUENCER -- requirements
Module: sample_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_QUADS, default 5: number of sample-buffer entries filled per sample, legal range 2..64.
REQ-002 The block SHALL have parameter SRC_BASE, default 16'h0000: register address read into entry 1; entry k reads SRC_BASE+k-1.
REQ-003 The block SHALL have port sysclk, input, 1: the single system clock (49.152 MHz).
REQ-004 The block SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-005 The block SHALL have port sample_start, input, 1: one-cycle request to begin a sample.
REQ-006 The block SHALL have port sample_busy, output, 1: sample in progress.
REQ-007 The block SHALL have port timestamp, input, 32: free-running timestamp.
REQ-008 The block SHALL have port sample_raddr, input, 6: sample-buffer read address.
REQ-009 The block SHALL have port sample_rdata, output, 32: sample-buffer read data.
REQ-010 The block SHALL have port host_ren, input, 1: the host (Firewire/Ethernet) claims the register read port this cycle.
REQ-011 The block SHALL have port host_raddr, input, 16: host read address.
REQ-012 The block SHALL have port bus_raddr, output, 16: address driven to the shared register read port.
REQ-013 The block SHALL have port bus_rdata, input, 32: register read data, valid one cycle after its address.

Function
REQ-014 States SHALL be IDLE, RUN and DRAIN.
REQ-015 bus_raddr SHALL equal host_raddr when host_ren=1, and otherwise SRC_BASE+idx-1, combinationally.
REQ-016 In IDLE, sample_start=1 at an edge SHALL:
- write the timestamp into entry 0;
- set idx=1 and sample_busy=1;
- go to RUN.
REQ-017 In RUN, at each edge with host_ren=0 (issue), the block SHALL set pending=1, set pidx=idx and increment idx.
REQ-018 In RUN, at each edge with host_ren=1 (stall), the block SHALL hold idx and set pending=0.
REQ-019 At any edge with pending=1, the block SHALL write bus_rdata into entry pidx.
REQ-020 The issue for idx=NUM_QUADS-1 SHALL move the block to DRAIN.
REQ-021 DRAIN SHALL write the last pending entry, clear sample_busy and return to IDLE on that same edge.
REQ-022 With no stalls, sample_busy SHALL be high exactly NUM_QUADS cycles; each stall cycle SHALL add one cycle.
REQ-023 sample_start while sample_busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-024 sample_start in the DRAIN cycle SHALL be ignored.
REQ-025 sample_rdata SHALL be registered: it shows entry[sample_raddr] one cycle after the address.
REQ-026 Reads SHALL be allowed at all times.
REQ-027 A read of the entry being written on the same edge SHALL return the old value.
REQ-028 A read with sample_raddr >= NUM_QUADS SHALL return that entry's stale contents.
REQ-029 idx and pidx SHALL be 7 bits wide.
REQ-030 Address arithmetic SHALL be 16-bit and wrap modulo 2^16.

Reset
REQ-031 Reset SHALL force state=IDLE, sample_busy=0, pending=0, idx=0, pidx=0 and sample_rdata=0 asynchronously.
REQ-032 Buffer contents SHALL NOT be reset.
REQ-033 Reset mid-sample SHALL abandon the sample with no further buffer writes; entries already written remain.

Structure
REQ-034 The state encoding, the NUM_QUADS maximum (64) and the default SRC_BASE SHALL live in the shared constants package.
REQ-035 The 64x32 buffer SHALL be a sub-module sample_buf_dp: one write port, one synchronous read port, inferred block RAM.

Verification
REQ-036 Scenario: NUM_QUADS=5, SRC_BASE=16'h0010, bus_rdata=16'hA000+address, timestamp=32'h1234 at start, no stalls.
- Response: sample_busy high 5 cycles; bus_raddr sequence 0x10,0x11,0x12,0x13.
- Response: buffer = {0x1234, 0xA010, 0xA011, 0xA012, 0xA013}.
REQ-037 Scenario: same setup, host_ren=1 with host_raddr=0x0400 on cycles 2 and 3 after start.
- Response: bus_raddr=0x0400 on those cycles; sample_busy high 7 cycles; buffer contents identical to REQ-036.
REQ-038 Scenario: sample_start pulsed again 2 cycles after the first start.
- Response: ignored; sample_busy high exactly 5 cycles; entry 0 holds the first timestamp.
REQ-039 Scenario: reset asserted 2 cycles after start.
- Response: sample_busy=0 immediately; entries 3 and 4 unchanged from prior contents.
- Response: a new start afterwards completes normally.
REQ-040 Scenario: sample_raddr=3 held across the write of entry 3.
- Response: sample_rdata shows the old value, then the new value one cycle later.
REQ-041 Scenario: NUM_QUADS=64, SRC_BASE=16'hFFF0.
- Response: address wraps 0xFFFF to 0x0000 at entry 17; busy 64 cycles; entry 63 written.
